// File: rtl/program_loader_if.sv
// Byte-stream input and i-cache write/status bundle for the program loader.
// The slave side is the loader; the master side is the stream source and CPU/i-cache.
interface program_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] program_in;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, download_program, instruction_index, program_in,
               busy, error, words_loaded
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, download_program, instruction_index, program_in,
               busy, error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed halfword program from a byte stream into the
// i-cache, holding the CPU until the whole image has been received and verified.
module program_loader #(
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  START_BYTE     = 8'hA5
) (
    input logic              clk,
    input logic              reset_n,
    program_loader_if.slave  bus
);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StLenLo  = 4'd1;
    localparam logic [3:0] StLenHi  = 4'd2;
    localparam logic [3:0] StDataHi = 4'd3;
    localparam logic [3:0] StDataLo = 4'd4;
    localparam logic [3:0] StWrite  = 4'd5;
    localparam logic [3:0] StCheck  = 4'd6;
    localparam logic [3:0] StRun    = 4'd7;
    localparam logic [3:0] StError  = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] idx_q, idx_d;
    logic [15:0] data_q, data_d;
    logic [15:0] wl_q, wl_d;

    logic        accept;
    logic        busy_w;
    logic        tmo_hit;
    logic [15:0] len_full;

    assign busy_w   = (state_q >= StLenLo) && (state_q <= StCheck);
    assign accept   = bus.byte_valid && (state_q != StWrite);
    assign tmo_hit  = busy_w && !accept && (tmo_q >= TIMEOUT_CYCLES - 32'd1);
    assign len_full = {bus.byte_in, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wl_d    = wl_q;
        tmo_d   = tmo_q;

        if (accept) begin
            tmo_d = 32'd0;
        end else if (busy_w) begin
            tmo_d = tmo_q + 32'd1;
        end

        case (state_q)
            StIdle, StRun, StError: begin
                // Index and data are cleared together so the i-cache never sees a mixed pair.
                if (accept && (bus.byte_in == START_BYTE)) begin
                    state_d = StLenLo;
                    csum_d  = 8'd0;
                    cnt_d   = 16'd0;
                    idx_d   = 32'd0;
                    data_d  = 16'd0;
                    tmo_d   = 32'd0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = bus.byte_in;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if ((len_full == 16'd0) || ({16'd0, len_full} > MAX_WORDS)) begin
                        state_d = StError;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    hi_d    = bus.byte_in;
                    csum_d  = csum_q ^ bus.byte_in;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    lo_d    = bus.byte_in;
                    csum_d  = csum_q ^ bus.byte_in;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                data_d = {hi_q, lo_q};
                idx_d  = {16'd0, cnt_q};
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q + 16'd1 == len_q) begin
                    state_d = StCheck;
                end else begin
                    state_d = StDataHi;
                end
            end
            StCheck: begin
                if (accept) begin
                    if (bus.byte_in == csum_q) begin
                        state_d = StRun;
                        wl_d    = len_q;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (tmo_hit) begin
            state_d = StError;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            len_q   <= 16'd0;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
            csum_q  <= 8'd0;
            cnt_q   <= 16'd0;
            tmo_q   <= 32'd0;
            idx_q   <= 32'd0;
            data_q  <= 16'd0;
            wl_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wl_q    <= wl_d;
        end
    end

    assign bus.byte_ready        = (state_q != StWrite);
    assign bus.download_program  = (state_q != StRun);
    assign bus.busy              = busy_w;
    assign bus.error             = (state_q == StError);
    assign bus.instruction_index = idx_q;
    assign bus.program_in        = data_q;
    assign bus.words_loaded      = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: packet-level reference model checks writes, status and timeout.
module tb_program_loader;

    localparam int unsigned MaxWords = 1024;
    localparam int unsigned TmoCyc   = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    program_loader_if bus ();

    program_loader #(
        .MAX_WORDS      (MaxWords),
        .TIMEOUT_CYCLES (TmoCyc),
        .START_BYTE     (8'hA5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          stalls;
    logic [47:0] wr_log[$];
    logic [15:0] pkt[$];
    logic [15:0] model_wl;
    logic        prev_wr;

    // A write lands on the edge that ends the ready-low cycle; record the pair after it.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_wr <= 1'b0;
        end else begin
            if (prev_wr) wr_log.push_back({bus.instruction_index, bus.program_in});
            prev_wr <= !bus.byte_ready;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.byte_ready) break;
            stalls++;
        end
        if (n == 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte: byte_ready got 0 for 50 cycles want 1 (byte %h)", b);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int gmax);
        int k;
        if (gmax > 0) begin
            bus.byte_valid = 1'b0;
            k = $urandom_range(0, gmax);
            repeat (k) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Sends one full packet using pkt[] as payload and checks the outcome against the model.
    task automatic run_packet(input logic [15:0] len, input bit bad_csum, input int gmax,
                              input bit chk_stalls, input string name);
        logic [7:0]  cs;
        logic [47:0] exp_w;
        bit          len_ok;
        bit          exp_err;
        logic [15:0] exp_wl;
        int          exp_n;
        len_ok  = (len != 16'd0) && (int'(len) <= MaxWords);
        exp_err = !len_ok || bad_csum;
        exp_wl  = exp_err ? model_wl : len;
        exp_n   = len_ok ? int'(len) : 0;
        wr_log.delete();
        stalls = 0;
        cs = 8'd0;
        send_byte(8'hA5);       gap(gmax);
        send_byte(len[7:0]);    gap(gmax);
        send_byte(len[15:8]);
        if (len_ok) begin
            for (int i = 0; i < int'(len); i++) begin
                gap(gmax);
                send_byte(pkt[i][15:8]);
                gap(gmax);
                send_byte(pkt[i][7:0]);
                cs = cs ^ pkt[i][15:8] ^ pkt[i][7:0];
            end
            gap(gmax);
            send_byte(cs ^ {7'd0, bad_csum});
        end
        bus.byte_valid = 1'b0;
        model_wl = exp_wl;

        n_tests++;
        if (bus.error !== exp_err) begin
            n_fail++;
            $display("FAIL %s.error: got %0b want %0b", name, bus.error, exp_err);
        end
        n_tests++;
        if (bus.download_program !== exp_err) begin
            n_fail++;
            $display("FAIL %s.download_program: got %0b want %0b", name,
                     bus.download_program, exp_err);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s.busy: got %0b want 0", name, bus.busy);
        end
        n_tests++;
        if (bus.words_loaded !== exp_wl) begin
            n_fail++;
            $display("FAIL %s.words_loaded: got %0d want %0d", name, bus.words_loaded, exp_wl);
        end
        n_tests++;
        if (wr_log.size() != exp_n) begin
            n_fail++;
            $display("FAIL %s.write_count: got %0d want %0d", name, wr_log.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                exp_w = {32'(i), pkt[i]};
                n_tests++;
                if (wr_log[i] !== exp_w) begin
                    n_fail++;
                    $display("FAIL %s.write[%0d]: got idx %0d data %h want idx %0d data %h",
                             name, i, wr_log[i][47:16], wr_log[i][15:0], i, pkt[i]);
                end
            end
        end
        if (chk_stalls) begin
            n_tests++;
            if (stalls != exp_n) begin
                n_fail++;
                $display("FAIL %s.ready_low_cycles: got %0d want %0d", name, stalls, exp_n);
            end
        end
    endtask

    task automatic fill_random(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(16'($urandom));
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if ({bus.byte_ready, bus.download_program, bus.busy, bus.error} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s.flags: got rdy/dl/busy/err %b want 1100", name,
                     {bus.byte_ready, bus.download_program, bus.busy, bus.error});
        end
        n_tests++;
        if (bus.instruction_index !== 32'd0 || bus.program_in !== 16'd0) begin
            n_fail++;
            $display("FAIL %s.pair: got idx %0d data %h want idx 0 data 0000", name,
                     bus.instruction_index, bus.program_in);
        end
        n_tests++;
        if (bus.words_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL %s.words_loaded: got %0d want 0", name, bus.words_loaded);
        end
    endtask

    task automatic test_reset();
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        reset_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n  = 1'b1;
        model_wl = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_ignore();
        logic [7:0] j[3];
        j[0] = 8'h00; j[1] = 8'hA4; j[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            send_byte(j[i]);
            n_tests++;
            if (bus.busy !== 1'b0 || bus.download_program !== 1'b1) begin
                n_fail++;
                $display("FAIL ignore[%0d]: got busy %0b dl %0b want busy 0 dl 1", i,
                         bus.busy, bus.download_program);
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_basic();
        pkt.delete();
        pkt.push_back(16'h1234);
        pkt.push_back(16'h5678);
        run_packet(16'd2, 1'b0, 0, 1'b0, "basic");
    endtask

    task automatic test_bad_csum();
        run_packet(16'd2, 1'b1, 0, 1'b0, "bad_csum");
        run_packet(16'd2, 1'b0, 1, 1'b0, "recover");
    endtask

    task automatic test_bad_len();
        run_packet(16'h0401, 1'b0, 0, 1'b0, "len_over");
        run_packet(16'h0000, 1'b0, 0, 1'b0, "len_zero");
        fill_random(int'(MaxWords));
        run_packet(16'(MaxWords), 1'b0, 0, 1'b0, "len_max");
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAB);
        bus.byte_valid = 1'b0;
        for (int k = 1; k <= int'(TmoCyc); k++) begin
            @(posedge clk);
            #1;
            if (k == int'(TmoCyc) - 1) begin
                n_tests++;
                if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_early: got err %0b busy %0b at %0d want err 0 busy 1",
                             bus.error, bus.busy, k);
                end
            end
        end
        n_tests++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: got err %0b busy %0b want err 1 busy 0",
                     bus.error, bus.busy);
        end
        n_tests++;
        if (bus.words_loaded !== model_wl) begin
            n_fail++;
            $display("FAIL timeout_wl: got %0d want %0d", bus.words_loaded, model_wl);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(3);
        run_packet(16'd3, 1'b0, 0, 1'b1, "back_to_back");
    endtask

    task automatic test_mid_reset();
        fill_random(8);
        run_packet(16'd3, 1'b0, 0, 1'b0, "pre_reset");
        fill_random(8);
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_byte(pkt[i][15:8]);
            send_byte(pkt[i][7:0]);
        end
        send_byte(pkt[4][15:8]);
        bus.byte_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        wr_log.delete();
        model_wl = 16'd0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (wr_log.size() != 0 || bus.busy !== 1'b0 || bus.download_program !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got writes %0d busy %0b dl %0b want 0 0 1",
                     wr_log.size(), bus.busy, bus.download_program);
        end
        fill_random(2);
        run_packet(16'd2, 1'b0, 0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        int          kind;
        logic [15:0] len;
        logic [7:0]  junk;
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 9);
            len  = 16'($urandom_range(1, 8));
            fill_random(8);
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(MaxWords + $urandom_range(1, 50));
            end
            run_packet(len, (kind == 1 || kind == 2), 3, 1'b0, "random");
            if ($urandom_range(0, 1) == 1) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
                bus.byte_valid = 1'b0;
                n_tests++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_junk: got busy %0b want 0 (byte %h)", bus.busy, junk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_basic();
        test_bad_csum();
        test_bad_len();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024: maximum accepted program length in halfwords.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between bytes inside a transfer.
REQ-003 SHALL have parameter START_BYTE, default 8'hA5: load-start command byte.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port byte_in  input  8  incoming stream byte (e.g. from UART RX).
REQ-007 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 SHALL have port download_program  output  1  holds the CPU and enables i-cache writes.
REQ-010 SHALL have port instruction_index  output  32  i-cache write index, in halfwords.
REQ-011 SHALL have port program_in  output  16  i-cache write data.
REQ-012 SHALL have port busy  output  1  transfer in progress.
REQ-013 SHALL have port error  output  1  last transfer failed.
REQ-014 SHALL have port words_loaded  output  16  halfwords written by the last successful load.

Function
REQ-015 SHALL transfer a byte only on a rising edge where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 in every state except WRITE.
REQ-016 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA_HI, DATA_LO, WRITE, CHECK, RUN, ERROR.
REQ-017 IDLE/RUN/ERROR: accepted byte == START_BYTE -> LEN_LO, clear error, csum:=0, instruction_index:=0; any other byte SHALL be consumed and ignored.
REQ-018 LEN_LO stores length[7:0]; LEN_HI stores length[15:8], then length==0 or length>MAX_WORDS -> ERROR, else -> DATA_HI.
REQ-019 DATA_HI latches byte as hi, DATA_LO latches lo; both XOR into csum; DATA_LO -> WRITE.
REQ-020 WRITE (exactly 1 cycle): program_in:={hi,lo} and instruction_index:=write count, both updated on the same edge; count+1==length -> CHECK, else -> DATA_HI.
REQ-021 instruction_index and program_in SHALL never change on different edges, so every cycle with download_program=1 presents a consistent pair (the i-cache writes every such cycle).
REQ-022 Byte order: first stream byte of each halfword SHALL go to program_in[15:8] (raw memory order; no swapping in this block).
REQ-023 CHECK: accepted byte == csum -> RUN, words_loaded:=length; mismatch -> ERROR.
REQ-024 download_program SHALL be 1 in every state except RUN, and 0 in RUN, so the CPU executes only a fully verified program.
REQ-025 busy SHALL be 1 in LEN_LO through CHECK inclusive, 0 otherwise; error SHALL be 1 only in ERROR.
REQ-026 Timeout counter SHALL clear on every accepted byte and on entry to LEN_LO, count only while busy=1, and on reaching TIMEOUT_CYCLES -> ERROR.
REQ-027 START_BYTE received while busy=1 SHALL be treated as data, not as restart.
REQ-028 Reaching ERROR SHALL leave words_loaded unchanged; i-cache contents may be partial.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, download_program=1, byte_ready=1, busy=0, error=0, instruction_index=0, program_in=0, words_loaded=0, csum=0, counters=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no further write beyond the reset pair (index 0, data 0).
REQ-031 After reset release the CPU SHALL stay held (IDLE) until a successful load.

Verification
REQ-032 Stream A5,02,00,12,34,56,78,(12^34^56^78=08) -> writes {0:1234},{1:5678}; state RUN, download_program=0, words_loaded=2, error=0.
REQ-033 Same stream with checksum 09 -> ERROR, error=1, download_program=1, words_loaded unchanged; then a good stream -> RUN, error=0.
REQ-034 Length 0x0401 (MAX_WORDS=1024) or 0x0000 -> ERROR immediately after LEN_HI byte, no write performed.
REQ-035 TIMEOUT_CYCLES=16: stop after A5,01,00,AB -> ERROR exactly 16 cycles after the last accepted byte.
REQ-036 byte_valid held high continuously through a 3-word load -> byte_ready low exactly one cycle per word (WRITE), no byte lost or duplicated.
REQ-037 reset_n pulsed low during DATA_LO of word 5 -> all outputs at reset values within the same cycle, IDLE after release, next A5 starts a clean load.
